irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Interrupt arbiter sitting between the bus peripherals (mouse, timer, IR and future sources) and the processor's single interrupt input. It latches per-source interrupt raises, applies a bus-writable mask, and selects one source at a time. It presents the selection to the processor as one raise/ack pair and routes the processor's acknowledge back to the granted source only. Status and mask registers are mapped on the shared 8-bit bus.

## Interface
Parameters:
- N_SRC, 4, number of interrupt sources; legal range 1..8
- BASE_ADDR, 8'hB0, bus base address; the block decodes BASE_ADDR..BASE_ADDR+2

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- BUS_DATA  inout  8  shared data bus; driven only during a read of this block, otherwise 8'hZZ
- BUS_ADDR  in  8  bus address
- BUS_WE  in  1  processor write strobe
- SRC_RAISE  in  N_SRC  per-source interrupt raise; level, held by the source until acked
- SRC_ACK  out  N_SRC  per-source acknowledge; one-hot, one-cycle pulse
- CPU_INT_RAISE  out  1  interrupt request to the processor
- CPU_INT_ACK  in  1  processor acknowledge

## Operation
Register map:
- BASE+0 MASK: read/write; bits[N_SRC-1:0] enable the sources; upper bits read 0
- BASE+1 PENDING: read-only; latched raises, masked and unmasked
- BASE+2 ACTIVE: read-only; bit7 = grant valid; bits[2:0] = granted source ID; other bits 0

Pending:
- pending[i] is set on any edge where SRC_RAISE[i]=1
- pending[i] is cleared on the edge where SRC_ACK[i]=1; the clear wins over a simultaneous set
- A source still raising on the following edge re-pends

Eligibility:
- eligible = pending & MASK
- Default selection is fixed priority; the lowest index wins

FSM states:
- IDLE:
  - CPU_INT_RAISE=0
  - if eligible≠0, latch the selected ID into ACTIVE and go to GRANT
- GRANT:
  - CPU_INT_RAISE=1 and ACTIVE bit7=1
  - on CPU_INT_ACK=1, go to ACK
  - a mask change in GRANT does not revoke the grant
- ACK:
  - SRC_ACK[ID]=1 and CPU_INT_RAISE=0
  - unconditionally go to IDLE; ACTIVE bit7 clears
- CPU_INT_ACK outside GRANT is ignored
- The ACK→IDLE pass guarantees at least one cycle of CPU_INT_RAISE low between grants

Bus access:
- Write: if BUS_WE=1 and BUS_ADDR==BASE_ADDR, then MASK <= BUS_DATA[N_SRC-1:0] on that edge; writes to BASE+1 and BASE+2 are ignored
- Read: on each edge, a read-enable flop <= (address in range) & !BUS_WE, and the output flop <= the selected register
- BUS_DATA is driven from the output flop while the read-enable flop is 1

## Timing
- Reset values:
  - MASK = all N_SRC bits 1
  - PENDING = 0, ACTIVE = 0
  - FSM = IDLE
  - CPU_INT_RAISE = 0, SRC_ACK = 0
  - BUS_DATA released (Z)
- Raise to request: SRC_RAISE high sampled at edge k sets pending; IDLE at edge k+1 enters GRANT, so CPU_INT_RAISE is high after edge k+1 (2-cycle latency).
- Ack: CPU_INT_ACK sampled at edge m in GRANT gives SRC_ACK pulse and CPU_INT_RAISE low after edge m; IDLE after edge m+1. Earliest next CPU_INT_RAISE is after edge m+2.
- Bus read latency: 1 cycle, address at edge n gives data valid after edge n.
- A MASK write takes effect for arbitration on the next edge.
- Reset mid-GRANT or mid-ACK: all outputs go to reset values immediately and asynchronously. No SRC_ACK is issued for the aborted grant.

## Configuration
- IRQ_ARB_ROUND_ROBIN_EN defined:
  - the search starts at (last granted ID + 1) mod N_SRC and wraps
  - the last granted ID resets to N_SRC-1, so the first search starts at 0
  - a source just served has lowest priority among the eligible sources
- Undefined: fixed priority, lowest index wins; no last-ID register.

## Test plan
- After reset, read BASE+0 → 8'h0F (N_SRC=4); read BASE+1 → 8'h00; CPU_INT_RAISE=0.
- SRC_RAISE[2] high at edge k → CPU_INT_RAISE=1 after edge k+1. Read BASE+2 → 8'h82. CPU_INT_ACK pulse → SRC_ACK=4'b0100 for exactly 1 cycle. PENDING[2]=0 after the source drops its raise.
- SRC_RAISE=4'b1010 held with repeated acks:
  - fixed priority: grants 1,1,1…
  - with IRQ_ARB_ROUND_ROBIN_EN: grants 1,3,1,3
- Write 8'h0D to BASE+0, then raise source 1 → PENDING=8'h02, no CPU_INT_RAISE. Write 8'h0F → CPU_INT_RAISE within 2 cycles.
- Assert RESET while in GRANT with ID 0 → CPU_INT_RAISE=0 and ACTIVE=0 immediately; SRC_ACK never pulses.
- CPU_INT_ACK pulse while in IDLE → no SRC_ACK. Bus write to BASE+2 → ACTIVE unchanged. BUS_DATA is Z when BUS_WE=1 or the address is outside BASE..BASE+2.

Source files
------------

// File: rtl/irq_arbiter.sv
// irq_arbiter: latched, maskable interrupt arbiter with bus-mapped MASK/PENDING/ACTIVE registers.
// Define IRQ_ARB_ROUND_ROBIN_EN for round-robin selection instead of fixed lowest-index priority.
module irq_arbiter #(
  parameter int N_SRC = 4,
  parameter logic [7:0] BASE_ADDR = 8'hB0
) (
  input  logic             CLK,
  input  logic             RESET,
  inout  wire  [7:0]       BUS_DATA,
  input  logic [7:0]       BUS_ADDR,
  input  logic             BUS_WE,
  input  logic [N_SRC-1:0] SRC_RAISE,
  output logic [N_SRC-1:0] SRC_ACK,
  output logic             CPU_INT_RAISE,
  input  logic             CPU_INT_ACK
);
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
  state_t state;
  logic [N_SRC-1:0] mask, pending, eligible, id_vec, clr;
  logic [2:0] id, sel;
  logic act, rd_en, hit;
  logic [7:0] rd_q, offset, rd_mux;
  assign eligible = pending & mask;
  assign clr = (state == GRANT && CPU_INT_ACK) ? id_vec : '0;
  assign offset = BUS_ADDR - BASE_ADDR;
  assign hit = offset < 8'd3;
  assign rd_mux = offset == 8'd0 ? 8'(mask) : offset == 8'd1 ? 8'(pending) : {act, 4'b0, id};
  assign BUS_DATA = rd_en ? rd_q : 8'hzz;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [2:0] last_id;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) last_id <= 3'(N_SRC - 1);
    else if (state == IDLE && |eligible) last_id <= sel;
`endif
  // Eligible source with the smallest distance from the search start wins.
  always_comb begin
    int base, d, best;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
    base = int'(last_id) + 1;
`else
    base = 0;
`endif
    sel = '0;
    best = N_SRC;
    for (int i = 0; i < N_SRC; i++) begin
      d = i - base;
      if (d < 0) d = d + N_SRC;
      if (eligible[i] && d < best) begin
        best = d;
        sel = 3'(i);
      end
    end
  end
  always_comb begin
    id_vec = '0;
    for (int i = 0; i < N_SRC; i++) id_vec[i] = (int'(id) == i);
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      mask <= '1;
      pending <= '0;
      id <= '0;
      act <= 1'b0;
      CPU_INT_RAISE <= 1'b0;
      SRC_ACK <= '0;
      rd_en <= 1'b0;
      rd_q <= '0;
    end else begin
      pending <= (pending | SRC_RAISE) & ~clr;
      SRC_ACK <= clr;
      rd_en <= hit && !BUS_WE;
      rd_q <= rd_mux;
      if (BUS_WE && BUS_ADDR == BASE_ADDR) mask <= BUS_DATA[N_SRC-1:0];
      case (state)
        IDLE: if (|eligible) begin
          id <= sel;
          act <= 1'b1;
          CPU_INT_RAISE <= 1'b1;
          state <= GRANT;
        end
        GRANT: if (CPU_INT_ACK) begin
          CPU_INT_RAISE <= 1'b0;
          state <= ACK;
        end
        default: begin
          act <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed bench for irq_arbiter; a released bus reads 8'hFF through the pullups.
module tb_irq_arbiter;
  localparam int N = 4;
  logic CLK = 0, RESET = 1, BUS_WE = 0, CPU_INT_RAISE, CPU_INT_ACK = 0, drv = 0;
  logic [7:0] BUS_ADDR = 0, wdata = 0, q;
  logic [N-1:0] SRC_RAISE = 0, SRC_ACK;
  wire [7:0] BUS_DATA;
  int tests = 0, fails = 0;
  typedef struct packed {logic we; logic [7:0] addr, wdata, exp;} vec_t;
  vec_t tbl [15];
  assign BUS_DATA = drv ? wdata : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (BUS_DATA[g]);
  end
  always #5 CLK = ~CLK;
  irq_arbiter #(.N_SRC(N), .BASE_ADDR(8'hB0)) dut (
    .CLK(CLK), .RESET(RESET), .BUS_DATA(BUS_DATA), .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE),
    .SRC_RAISE(SRC_RAISE), .SRC_ACK(SRC_ACK), .CPU_INT_RAISE(CPU_INT_RAISE), .CPU_INT_ACK(CPU_INT_ACK)
  );
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic rd(input logic [7:0] a, output logic [7:0] r);
    BUS_ADDR = a;
    BUS_WE = 0;
    tick();
    r = BUS_DATA;
    BUS_ADDR = 8'h00;
  endtask
  // Park the bus for one cycle first so a preceding read is not still driving it.
  task automatic wr(input logic [7:0] a, input logic [7:0] d, output logic [7:0] r);
    BUS_ADDR = 8'h00;
    BUS_WE = 0;
    tick();
    BUS_ADDR = a;
    wdata = d;
    drv = 1;
    BUS_WE = 1;
    tick();
    drv = 0;
    BUS_WE = 0;
    BUS_ADDR = 8'h00;
    #1;
    r = BUS_DATA;
  endtask
  task automatic wait_grant(input string nm);
    int n = 0;
    while (!CPU_INT_RAISE && n < 8) begin
      tick();
      n++;
    end
    chk(nm, 8'(CPU_INT_RAISE), 8'h01);
  endtask
  task automatic drain();
    SRC_RAISE = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (CPU_INT_RAISE) begin
        CPU_INT_ACK = 1;
        tick();
        CPU_INT_ACK = 0;
      end
    end
  endtask
  initial begin
    int exp_id, nack;
    tbl[0]  = '{1'b0, 8'hB0, 8'h00, 8'h0F};
    tbl[1]  = '{1'b0, 8'hB1, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 8'hB2, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 8'hB3, 8'h00, 8'hFF};
    tbl[4]  = '{1'b0, 8'hAF, 8'h00, 8'hFF};
    tbl[5]  = '{1'b1, 8'hB0, 8'h0D, 8'hFF};
    tbl[6]  = '{1'b0, 8'hB0, 8'h00, 8'h0D};
    tbl[7]  = '{1'b1, 8'hB1, 8'hFF, 8'hFF};
    tbl[8]  = '{1'b0, 8'hB1, 8'h00, 8'h00};
    tbl[9]  = '{1'b1, 8'hB2, 8'hFF, 8'hFF};
    tbl[10] = '{1'b0, 8'hB2, 8'h00, 8'h00};
    tbl[11] = '{1'b1, 8'hB0, 8'h0F, 8'hFF};
    tbl[12] = '{1'b0, 8'hB0, 8'h00, 8'h0F};
    tbl[13] = '{1'b1, 8'h50, 8'h03, 8'hFF};
    tbl[14] = '{1'b0, 8'hB0, 8'h00, 8'h0F};
    repeat (3) tick();
    RESET = 0;
    chk("rst_raise", 8'(CPU_INT_RAISE), 8'h00);
    chk("rst_ack", 8'(SRC_ACK), 8'h00);
    chk("rst_bus", BUS_DATA, 8'hFF);
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata, q);
      else rd(tbl[i].addr, q);
      chk($sformatf("bus_vec%0d", i), q, tbl[i].exp);
    end
    chk("bus_idle_raise", 8'(CPU_INT_RAISE), 8'h00);
    SRC_RAISE = 4'b0100;
    tick();
    chk("lat_k", 8'(CPU_INT_RAISE), 8'h00);
    tick();
    chk("lat_k1", 8'(CPU_INT_RAISE), 8'h01);
    rd(8'hB2, q);
    chk("active_src2", q, 8'h82);
    CPU_INT_ACK = 1;
    tick();
    chk("ack_src2", 8'(SRC_ACK), 8'h04);
    chk("ack_raise_low", 8'(CPU_INT_RAISE), 8'h00);
    CPU_INT_ACK = 0;
    SRC_RAISE = 0;
    tick();
    chk("ack_one_cycle", 8'(SRC_ACK), 8'h00);
    rd(8'hB1, q);
    chk("pending_cleared", q, 8'h00);
    chk("no_regrant", 8'(CPU_INT_RAISE), 8'h00);
    SRC_RAISE = 4'b1010;
    for (int n = 0; n < 4; n++) begin
`ifdef IRQ_ARB_ROUND_ROBIN_EN
      exp_id = (n % 2 == 0) ? 1 : 3;
`else
      exp_id = 1;
`endif
      wait_grant($sformatf("hold_grant%0d", n));
      rd(8'hB2, q);
      chk($sformatf("hold_id%0d", n), q, 8'h80 | 8'(exp_id));
      CPU_INT_ACK = 1;
      tick();
      chk($sformatf("hold_ack%0d", n), 8'(SRC_ACK), 8'(1 << exp_id));
      CPU_INT_ACK = 0;
      tick();
      chk($sformatf("hold_gap%0d", n), 8'(CPU_INT_RAISE), 8'h00);
    end
    drain();
    rd(8'hB1, q);
    chk("drained_pending", q, 8'h00);
    wr(8'hB0, 8'h0D, q);
    SRC_RAISE = 4'b0010;
    repeat (3) tick();
    chk("masked_raise", 8'(CPU_INT_RAISE), 8'h00);
    rd(8'hB1, q);
    chk("masked_pending", q, 8'h02);
    wr(8'hB0, 8'h0F, q);
    chk("unmask_edge", 8'(CPU_INT_RAISE), 8'h00);
    tick();
    chk("unmask_next", 8'(CPU_INT_RAISE), 8'h01);
    CPU_INT_ACK = 1;
    tick();
    chk("unmask_ack", 8'(SRC_ACK), 8'h02);
    CPU_INT_ACK = 0;
    drain();
    SRC_RAISE = 4'b0001;
    wait_grant("rst_grant");
    rd(8'hB2, q);
    chk("rst_active_pre", q, 8'h80);
    #2;
    RESET = 1;
    #1;
    chk("async_raise", 8'(CPU_INT_RAISE), 8'h00);
    chk("async_ack", 8'(SRC_ACK), 8'h00);
    chk("async_bus", BUS_DATA, 8'hFF);
    SRC_RAISE = 0;
    CPU_INT_ACK = 1;
    repeat (2) tick();
    RESET = 0;
    CPU_INT_ACK = 0;
    nack = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (SRC_ACK != 0) nack++;
    end
    chk("aborted_no_ack", 8'(nack), 8'h00);
    rd(8'hB2, q);
    chk("rst_active_post", q, 8'h00);
    rd(8'hB1, q);
    chk("rst_pending_post", q, 8'h00);
    CPU_INT_ACK = 1;
    tick();
    chk("idle_ack0", 8'(SRC_ACK), 8'h00);
    tick();
    chk("idle_ack1", 8'(SRC_ACK), 8'h00);
    CPU_INT_ACK = 0;
    chk("idle_ack_raise", 8'(CPU_INT_RAISE), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
